// File: rtl/uart_tx_frame_if.sv
// Parallel-to-serial handshake between the character source and the UART transmitter.
// The source drives the word and its strobe; the transmitter returns the line and BUSY.
interface uart_tx_frame_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  DATA_VALID;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  TX_OUT;
    logic                  BUSY;

    modport master (
        output P_DATA,
        output DATA_VALID,
        output PAR_EN,
        output PAR_TYP,
        input  TX_OUT,
        input  BUSY
    );

    modport slave (
        input  P_DATA,
        input  DATA_VALID,
        input  PAR_EN,
        input  PAR_TYP,
        output TX_OUT,
        output BUSY
    );
endinterface

// File: rtl/uart_tx_frame.sv
// UART frame transmitter: start bit, LSB-first data, optional parity and a stop bit,
// one bit per baud-clock cycle, with registered TX_OUT/BUSY and back-to-back acceptance in STOP.
module uart_tx_frame #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic         CLK,
    input  logic         RST,
    uart_tx_frame_if.slave bus
);

    localparam int unsigned CntW = $clog2(DATA_WIDTH) + 1;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  par_en_q, par_en_d;
    logic                  par_bit_q, par_bit_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  accept;
    logic [DATA_WIDTH-1:0] shifted;

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        cnt_d     = cnt_q;
        accept    = 1'b0;

        case (state_q)
            StIdle: begin
                accept = bus.DATA_VALID;
            end
            StStart: begin
                state_d = StData;
                cnt_d   = '0;
            end
            StData: begin
                if (cnt_q == CntW'(DATA_WIDTH - 1)) begin
                    state_d = par_en_q ? StParity : StStop;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StParity: begin
                state_d = StStop;
            end
            StStop: begin
                accept  = bus.DATA_VALID;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (accept) begin
            state_d   = StStart;
            data_d    = bus.P_DATA;
            par_en_d  = bus.PAR_EN;
            par_bit_d = bus.PAR_TYP ? ~^bus.P_DATA : ^bus.P_DATA;
        end

        // Outputs are decoded from the next state so the registers present the bit for the
        // cycle that follows this edge.
        shifted = data_d >> cnt_d;
        tx_d    = 1'b1;
        busy_d  = 1'b1;
        case (state_d)
            StIdle:   busy_d = 1'b0;
            StStart:  tx_d   = 1'b0;
            StData:   tx_d   = shifted[0];
            StParity: tx_d   = par_bit_d;
            default:  tx_d   = 1'b1;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q   <= StIdle;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            cnt_q     <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            cnt_q     <= cnt_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.TX_OUT = tx_q;
    assign bus.BUSY   = busy_q;

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Serial transmitter for the UART interface: accepts a parallel word on a valid strobe and shifts out one framed character on TX_OUT. The frame is start bit, DATA_WIDTH data bits LSB first, an optional even/odd parity bit, and a stop bit. The block runs on the TX baud clock, one serial bit per CLK cycle, and is the transmit-side counterpart of the RX sampling/parity-check path. BUSY provides back-pressure to the upstream data source (FIFO or register file).

## Interface
- DATA_WIDTH, 8, width of the character payload (≥ 1)
- CLK  input  1  TX baud clock; one serial bit per cycle
- RST  input  1  synchronous reset, active low
- P_DATA  input  DATA_WIDTH  parallel character, sampled on acceptance
- DATA_VALID  input  1  request to send P_DATA
- PAR_EN  input  1  1 = append parity bit, sampled on acceptance
- PAR_TYP  input  1  0 = even parity, 1 = odd parity, sampled on acceptance
- TX_OUT  output  1  serial line; idles high
- BUSY  output  1  high while a frame is on the line

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: TX_OUT=1, BUSY=0. If DATA_VALID=1, accept:
  - latch P_DATA, PAR_EN and PAR_TYP;
  - compute the parity bit from the latched data: even = ^data, odd = ~^data;
  - go to START.
- START: TX_OUT=0, BUSY=1, lasts one cycle, then DATA.
- DATA: TX_OUT = latched data bit[i] for i = 0 .. DATA_WIDTH-1, one cycle each.
  - Bit counter width is $clog2(DATA_WIDTH)+1; it is cleared on entry to DATA.
  - After bit DATA_WIDTH-1, go to PARITY if the latched PAR_EN=1, else STOP.
- PARITY: TX_OUT = latched parity bit, BUSY=1, one cycle, then STOP.
- STOP: TX_OUT=1, BUSY=1, one cycle.
  - If DATA_VALID=1 in this cycle, accept a new word exactly as in IDLE and go straight to START (back-to-back, no idle gap).
  - Otherwise go to IDLE.
- DATA_VALID in START, DATA or PARITY is ignored. The word is not queued. The source must hold DATA_VALID until it observes acceptance: BUSY low, or the STOP cycle.
- Changes on P_DATA, PAR_EN or PAR_TYP after acceptance do not affect the frame in flight.
- Illegal or unused state encodings recover to IDLE on the next edge.

## Timing
- Reset: RST=0 at a rising edge forces IDLE, TX_OUT=1, BUSY=0 and clears the data, parity and counter registers, from that edge onward.
  - This applies mid-frame too: the frame is aborted, and the line returns high with no stop-bit completion.
  - DATA_VALID is ignored while RST=0.
- TX_OUT and BUSY are registered Moore outputs with no combinational path from any input.
- Latency: DATA_VALID sampled high in IDLE at edge N gives start bit (TX_OUT=0, BUSY=1) in cycle N+1.
- Frame length = 2 + DATA_WIDTH + PAR_EN cycles: 11 for 8 data bits with parity, 10 for 8 data bits without.
- BUSY stays high for the whole frame, including STOP. It drops in the first IDLE cycle after STOP.
  - With a back-to-back accept in STOP, BUSY stays high continuously across both frames.
- Throughput: one frame per 2 + DATA_WIDTH + PAR_EN cycles with DATA_VALID held high.

## Test plan
- 0xA5, PAR_EN=1, PAR_TYP=0 -> TX_OUT over 11 cycles = 0, 1,0,1,0,0,1,0,1, 0, 1.
  - BUSY high for exactly those 11 cycles, starting 1 cycle after DATA_VALID.
- 0x00, PAR_EN=1, PAR_TYP=1 -> start 0, eight 0s, parity 1, stop 1. Repeat with 0x01 -> parity 0.
- 0xFF, PAR_EN=0 -> 10-cycle frame: 0, eight 1s, 1. No parity cycle, and BUSY falls after 10 cycles.
- DATA_VALID held high with 0x3C then 0xC3 (PAR_EN=1, PAR_TYP=0) -> the second start bit immediately follows the first stop bit with no idle cycle, and BUSY stays continuously high for 22 cycles.
- Mid-frame disturbance: during DATA bit 3, change P_DATA to 0x00, toggle PAR_TYP and pulse DATA_VALID -> the original frame completes unchanged and no extra frame is sent.
- Reset mid-frame: assert RST=0 for 1 cycle during DATA bit 4 -> TX_OUT=1 and BUSY=0 from that edge, and no stop/parity bit follows.
  - A subsequent DATA_VALID with 0x5A -> a normal full frame.
